// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/owner encodings and default widths for mem_arbiter.
package mem_arb_pkg;
    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_TIMEOUT_CYC = 255;

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;
    typedef enum logic {OWN_IF, OWN_LS} owner_t;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner selection between fetch and load/store requests.
// MEM_ARBITER_RR_EN selects round-robin tie-breaking; otherwise load/store wins ties.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic if_req,
    input  logic ls_req,
    input  logic last_ls,
    output logic valid,
    output logic win_ls
);
    assign valid = if_req | ls_req;
`ifdef MEM_ARBITER_RR_EN
    // a tie goes to whoever did not win the previous arbitration
    assign win_ls = (if_req && ls_req) ? !last_ls : ls_req;
`else
    logic unused_last;
    assign unused_last = last_ls;
    assign win_ls = ls_req;
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus between fetch and load/store, one transaction at a time,
// with a response watchdog; MEM_ARBITER_RR_EN enables round-robin tie-breaking.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_if_req,
    input  logic [ADDR_W-1:0]   i_if_addr,
    output logic                o_if_gnt,
    output logic                o_if_rvalid,
    output logic [DATA_W-1:0]   o_if_rdata,
    input  logic                i_ls_req,
    input  logic                i_ls_we,
    input  logic [DATA_W/8-1:0] i_ls_be,
    input  logic [ADDR_W-1:0]   i_ls_addr,
    input  logic [DATA_W-1:0]   i_ls_wdata,
    output logic                o_ls_gnt,
    output logic                o_ls_rvalid,
    output logic [DATA_W-1:0]   o_ls_rdata,
    output logic                o_mem_req,
    output logic                o_mem_we,
    output logic [DATA_W/8-1:0] o_mem_be,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    input  logic                i_mem_gnt,
    input  logic                i_mem_rvalid,
    input  logic [DATA_W-1:0]   i_mem_rdata,
    output logic                o_err
);
    localparam int BE_W = DATA_W / 8;
    localparam int CW   = $clog2(TIMEOUT_CYC + 1);

    state_t        state;
    owner_t        owner;
    owner_t        last;
    logic [CW-1:0] cnt;
    logic          pick_valid;
    logic          win_ls;
    logic          done;
    logic          timeout;
    logic          arb;
    logic          rsp;

    assign done    = state == RSP && i_mem_rvalid;
    assign timeout = state == RSP && !i_mem_rvalid && cnt == CW'(TIMEOUT_CYC - 1);
    assign arb     = state == IDLE || done;

    mem_arb_pick u_pick (
        .if_req  (i_if_req),
        .ls_req  (i_ls_req),
        .last_ls (last == OWN_LS),
        .valid   (pick_valid),
        .win_ls  (win_ls)
    );

`ifdef MEM_ARBITER_RR_EN
    always_ff @(posedge i_clk)
        if (!i_reset)
            last <= OWN_LS;
        else if (arb && pick_valid)
            last <= win_ls ? OWN_LS : OWN_IF;
`else
    assign last = OWN_LS;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state       <= IDLE;
            owner       <= OWN_IF;
            cnt         <= '0;
            o_mem_we    <= 1'b0;
            o_mem_be    <= '0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
        end else if (arb) begin
            state <= pick_valid ? REQ : IDLE;
            if (pick_valid) begin
                owner       <= win_ls ? OWN_LS : OWN_IF;
                o_mem_we    <= win_ls && i_ls_we;
                o_mem_be    <= win_ls ? i_ls_be : {BE_W{1'b1}};
                o_mem_addr  <= win_ls ? i_ls_addr : i_if_addr;
                o_mem_wdata <= win_ls ? i_ls_wdata : '0;
            end
        end else if (state == REQ && i_mem_gnt) begin
            state <= RSP;
            cnt   <= '0;
        end else if (timeout) begin
            state <= IDLE;
        end else if (state == RSP) begin
            cnt <= cnt + 1'b1;
        end
    end

    // handshake outputs are forced low while reset is asserted
    assign rsp         = i_reset && (done || timeout);
    assign o_mem_req   = i_reset && state == REQ;
    assign o_if_gnt    = o_mem_req && i_mem_gnt && owner == OWN_IF;
    assign o_ls_gnt    = o_mem_req && i_mem_gnt && owner == OWN_LS;
    assign o_if_rvalid = rsp && owner == OWN_IF;
    assign o_ls_rvalid = rsp && owner == OWN_LS;
    assign o_if_rdata  = (o_if_rvalid && done) ? i_mem_rdata : '0;
    assign o_ls_rdata  = (o_ls_rvalid && done) ? i_mem_rdata : '0;
    assign o_err       = i_reset && timeout;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester memory arbiter that shares one single-port memory bus between the singlecycle core's instruction-fetch port and its load/store port. It arbitrates, latches the winning request, drives the memory handshake and routes the response back to the owner, with one transaction outstanding at a time. A response watchdog converts a hung memory into an error response so the core can never deadlock.

## Interface
- ADDR_W, 32, address width for both requesters and memory
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- TIMEOUT_CYC, 255, maximum cycles in RSP before an error response (≥1)
- i_clk  in  1  clock, all logic on rising edge
- i_reset  in  1  synchronous, active-low reset
- i_if_req  in  1  fetch request, held until o_if_gnt
- i_if_addr  in  ADDR_W  fetch address
- o_if_gnt  out  1  fetch request accepted by memory
- o_if_rvalid  out  1  fetch response valid (one cycle)
- o_if_rdata  out  DATA_W  fetch read data
- i_ls_req  in  1  load/store request, held until o_ls_gnt
- i_ls_we  in  1  1 = store
- i_ls_be  in  DATA_W/8  byte enables
- i_ls_addr  in  ADDR_W  load/store address
- i_ls_wdata  in  DATA_W  store data
- o_ls_gnt  out  1  load/store accepted
- o_ls_rvalid  out  1  load/store response valid (stores too)
- o_ls_rdata  out  DATA_W  load data
- o_mem_req, o_mem_we  out  1  memory request / write
- o_mem_be  out  DATA_W/8;  o_mem_addr  out  ADDR_W;  o_mem_wdata  out  DATA_W
- i_mem_gnt  in  1  memory accepts o_mem_req
- i_mem_rvalid  in  1  memory response (reads and writes)
- i_mem_rdata  in  DATA_W  memory read data
- o_err  out  1  one-cycle pulse on response timeout

## Operation
- FSM states IDLE, REQ, RSP; reset state IDLE.
- Arbitration in IDLE, and in RSP on the cycle the response completes (back-to-back). Winner's request fields registered into o_mem_* and owner register; next state REQ. No request → IDLE.
- REQ: o_mem_req=1 with registered fields. On i_mem_gnt: owner's gnt=1 combinationally same cycle; next RSP. No gnt → remain in REQ, fields stable.
- RSP: on i_mem_rvalid, owner's rvalid=1 and rdata=i_mem_rdata same cycle (combinational pass-through); non-owner rvalid=0. i_mem_rvalid outside RSP ignored.
- Watchdog: counter cleared on RSP entry, increments each RSP cycle; reaching TIMEOUT_CYC without rvalid → owner rvalid=1, rdata=0, o_err=1, next IDLE (no same-cycle re-arbitration).
- Tie (both requests): fixed priority LS over IF unless round-robin compiled in.
- Reset value of every output: 0. Reset mid-transaction aborts it; late i_mem_rvalid then ignored (state IDLE).
- Request deasserted in IDLE before arbitration → no transaction; requester may not withdraw in REQ (protocol violation, undefined).

## Timing
- Cycle n: IDLE samples i_if_req=1. n+1: REQ, o_mem_req=1. If i_mem_gnt at n+1: o_if_gnt=1 at n+1. n+2: RSP; i_mem_rvalid at n+2 → o_if_rvalid=1 at n+2.
- Minimum request-to-response latency 2 cycles; peak throughput one transaction per 2 cycles.
- Back-to-back: completion cycle in RSP with pending request → REQ next cycle.

## Configuration
- MEM_ARBITER_RR_EN defined: round-robin; last-owner register (reset value LS) and ties go to the requester that did not win last, so first tie after reset goes to IF. Non-tie cases unaffected.
- Undefined: fixed priority, LS wins every tie; no last-owner register.

## Structure
- mem_arb_pkg: state enum (IDLE, REQ, RSP), owner enum (OWN_IF, OWN_LS), default width constants.
- One sub-module mem_arb_pick: combinational winner selection from two requests plus last owner, containing the MEM_ARBITER_RR_EN variants.

## Test plan
- Fetch only, i_mem_gnt immediate, rvalid next cycle, rdata 32'h0000_0013 → o_if_gnt at n+1, o_if_rvalid with 32'h0000_0013 at n+2, o_ls_* all 0.
- Both request at once, repeated 4 transactions → fixed: LS,LS… until LS drops; RR: IF,LS,IF,LS.
- Store addr 32'h100, be 4'b0011, gnt delayed 3 cycles → o_mem_* stable over 3 REQ cycles, o_ls_gnt only on 4th, o_ls_rvalid on response.
- No i_mem_rvalid, TIMEOUT_CYC=8 → after 8 RSP cycles owner rvalid=1, rdata=0, o_err=1 for one cycle, then IDLE.
- i_reset=0 during RSP, then rvalid arrives → all outputs 0, no o_*_rvalid, next request arbitrates normally.
